// File: rtl/psram_responder.sv
// Synchronous-burst PSRAM device model with config-register access and a 16-bit byte-enabled array.
// Optional macro PSRAM_RESP_BCR_EN: latency from BCR[13:11], sync accesses gated until a CFG write.
module psram_responder #(
    parameter int          MEM_AW  = 10,
    parameter logic [22:0] RST_BCR = 23'h009D1F
) (
    input  logic        clk_100,
    input  logic        reset_n,
    input  logic        mem_clk,
    input  logic [22:0] mem_addr,
    input  logic        mem_ce,
    input  logic        mem_adv,
    input  logic        mem_we,
    input  logic        mem_oe,
    input  logic        mem_ub,
    input  logic        mem_lb,
    input  logic        mem_cre,
    inout  wire  [15:0] mem_data,
    output logic [22:0] resp_bcr,
    output logic        resp_busy,
    output logic        resp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_LAT,
        S_WR_BURST,
        S_RD_BURST
    } state_t;

    localparam logic [MEM_AW-1:0] PTR_ONE = MEM_AW'(1);

    state_t            state_reg, state_next;
    logic              mclk_q_reg;
    logic              tick;
    logic [MEM_AW-1:0] ptr_reg, ptr_next;
    logic              dir_reg, dir_next;
    logic [2:0]        lat_cnt_reg, lat_cnt_next;
    logic [22:0]       cfg_addr_reg, cfg_addr_next;
    logic              cfg_wr_reg, cfg_wr_next;
    logic [22:0]       bcr_reg, bcr_next;
    logic              err_reg, err_next;
    logic [3:0]        lat_val;
    logic              accept_sync;
    logic [1:0]        wr_en;
    logic [15:0]       rd_data;
    logic              drive_en;

    assign tick = mem_clk & ~mclk_q_reg;

`ifdef PSRAM_RESP_BCR_EN
    logic cfg_done_reg;

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n)
            cfg_done_reg <= 1'b0;
        else if (state_reg == S_CFG && mem_ce && cfg_wr_reg)
            cfg_done_reg <= 1'b1;
    end

    assign accept_sync = cfg_done_reg;
    assign lat_val     = {1'b0, bcr_reg[13:11]} + 4'd1;
`else
    assign accept_sync = 1'b1;
    assign lat_val     = 4'd4;
`endif

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            mclk_q_reg   <= 1'b0;
            ptr_reg      <= '0;
            dir_reg      <= 1'b0;
            lat_cnt_reg  <= '0;
            cfg_addr_reg <= '0;
            cfg_wr_reg   <= 1'b0;
            bcr_reg      <= RST_BCR;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mclk_q_reg   <= mem_clk;
            ptr_reg      <= ptr_next;
            dir_reg      <= dir_next;
            lat_cnt_reg  <= lat_cnt_next;
            cfg_addr_reg <= cfg_addr_next;
            cfg_wr_reg   <= cfg_wr_next;
            bcr_reg      <= bcr_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        dir_next      = dir_reg;
        lat_cnt_next  = lat_cnt_reg;
        cfg_addr_next = cfg_addr_reg;
        cfg_wr_next   = cfg_wr_reg;
        bcr_next      = bcr_reg;
        err_next      = err_reg;
        wr_en         = 2'b00;
        case (state_reg)
            S_IDLE: begin
                if (!mem_ce && !mem_adv && mem_cre) begin
                    state_next    = S_CFG;
                    cfg_addr_next = mem_addr;
                    cfg_wr_next   = ~mem_we;
                end else if (tick && !mem_ce && !mem_adv && !mem_cre && accept_sync) begin
                    ptr_next     = mem_addr[MEM_AW-1:0];
                    dir_next     = mem_we;
                    lat_cnt_next = 3'(lat_val - 4'd1);
                    // A latency of one means word 0 is already due on the next tick.
                    if (lat_val == 4'd1)
                        state_next = mem_we ? S_RD_BURST : S_WR_BURST;
                    else
                        state_next = S_LAT;
                end
            end
            S_CFG: begin
                if (mem_ce) begin
                    state_next = S_IDLE;
                    if (cfg_wr_reg)
                        bcr_next = cfg_addr_reg;
                end else if (!mem_we) begin
                    cfg_wr_next = 1'b1;
                end
            end
            S_LAT: begin
                if (mem_ce) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                end else if (tick) begin
                    lat_cnt_next = lat_cnt_reg - 3'd1;
                    if (lat_cnt_reg == 3'd1)
                        state_next = dir_reg ? S_RD_BURST : S_WR_BURST;
                end
            end
            S_WR_BURST: begin
                if (mem_ce) begin
                    state_next = S_IDLE;
                end else if (tick) begin
                    wr_en    = {~mem_ub, ~mem_lb};
                    ptr_next = ptr_reg + PTR_ONE;
                end
            end
            S_RD_BURST: begin
                if (mem_ce)
                    state_next = S_IDLE;
                else if (tick)
                    ptr_next = ptr_reg + PTR_ONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Read port is addressed by ptr_next so the registered word always matches ptr_reg.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] lane_mem [0:(1<<MEM_AW)-1];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk_100) begin
                if (wr_en[gi])
                    lane_mem[ptr_reg] <= mem_data[gi*8 +: 8];
                lane_rd_reg <= lane_mem[ptr_next];
            end

            assign rd_data[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    assign drive_en  = (state_reg == S_RD_BURST) && !mem_ce && !mem_oe && mem_we;
    assign mem_data  = drive_en ? rd_data : 16'hzzzz;
    assign resp_bcr  = bcr_reg;
    assign resp_busy = (state_reg != S_IDLE);
    assign resp_err  = err_reg;

endmodule
